mul_float_pipe: RTL and testbench

Parametrised, fully pipelined floating-point multiplier; successor to the single-format mul_float_cal.
- Generic over exponent and mantissa width; IEEE-754-style sign/exponent/fraction layout.
- Selectable per-operation rounding mode; IEEE special values; exception flags.
- Accepts one operation per cycle with back-pressure. Sits between an issue queue and the writeback arbiter.

---
 rtl/float_mul_pkg.sv | 53 +++++
 rtl/mul_float_round.sv | 88 ++++++++
 rtl/mul_float_pipe.sv | 151 +++++++++++++++
 tb/tb_mul_float_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_mul_pkg.sv
// Shared types and IEEE-style bit-pattern helpers for the parametrised floating-point datapath.
package float_mul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_t;

    // Patterns are built at 64 bits; callers size-cast to their own operand width.
    function automatic logic [63:0] f_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    function automatic logic [63:0] f_inf(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        if (sign) begin
            r = r | (64'd1 << (exp_w + man_w));
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic logic [63:0] f_max_finite(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
        if (sign) begin
            r = r | (64'd1 << (exp_w + man_w));
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_float_round.sv
// Combinational normalise / round / pack of a raw mantissa product with special-value override.
module mul_float_round
    import float_mul_pkg::*;
#(
    parameter  int P_EXP_W = 8,
    parameter  int P_MAN_W = 23,
    localparam int P_W     = 1 + P_EXP_W + P_MAN_W,
    localparam int PROD_W  = 2 * P_MAN_W + 2
) (
    input  logic                 sign_i,
    input  rm_e                  rm_i,
    input  cls_e                 cls_i,
    input  logic [P_EXP_W+1:0]   exp_i,
    input  logic [PROD_W-1:0]    prod_i,
    output logic [P_W-1:0]       data_o,
    output flags_t               flags_o
);

    localparam logic [P_EXP_W:0] EXP_ONES = {1'b0, {P_EXP_W{1'b1}}};

    logic               msb_s;
    logic [P_MAN_W-1:0] frac_s;
    logic               guard_s;
    logic               sticky_s;
    logic               round_up_s;
    logic [P_MAN_W:0]   frac_rnd_s;
    logic [P_EXP_W+1:0] exp_f_s;
    logic               ovf_s;
    logic               unf_s;

    // Normalise, round, then choose between special, saturated and packed results.
    always_comb begin
        msb_s = prod_i[PROD_W-1];
        if (msb_s) begin
            frac_s   = prod_i[PROD_W-2 -: P_MAN_W];
            guard_s  = prod_i[P_MAN_W];
            sticky_s = |prod_i[P_MAN_W-1:0];
        end else begin
            frac_s   = prod_i[PROD_W-3 -: P_MAN_W];
            guard_s  = prod_i[P_MAN_W-1];
            sticky_s = |prod_i[P_MAN_W-2:0];
        end

        round_up_s = (rm_i == RM_RNE) && guard_s && (sticky_s || frac_s[0]);
        frac_rnd_s = {1'b0, frac_s} + {{P_MAN_W{1'b0}}, round_up_s};
        // exp_i is two's complement; a rounding carry-out leaves the fraction all-zero
        exp_f_s    = exp_i + {{(P_EXP_W+1){1'b0}}, msb_s}
                           + {{(P_EXP_W+1){1'b0}}, frac_rnd_s[P_MAN_W]};

        ovf_s = !exp_f_s[P_EXP_W+1] && (exp_f_s[P_EXP_W:0] >= EXP_ONES);
        unf_s = exp_f_s[P_EXP_W+1] || (exp_f_s == {(P_EXP_W+2){1'b0}});

        data_o  = {P_W{1'b0}};
        flags_o = flags_t'(4'b0000);
        case (cls_i)
            CLS_NAN: begin
                data_o          = P_W'(f_qnan(P_EXP_W, P_MAN_W));
                flags_o.invalid = 1'b1;
            end
            CLS_INF: begin
                data_o = P_W'(f_inf(sign_i, P_EXP_W, P_MAN_W));
            end
            CLS_ZERO: begin
                data_o = {sign_i, {(P_W-1){1'b0}}};
            end
            CLS_NORM: begin
                flags_o.inexact = guard_s || sticky_s;
                if (ovf_s) begin
                    data_o           = (rm_i == RM_RNE) ? P_W'(f_inf(sign_i, P_EXP_W, P_MAN_W))
                                                        : P_W'(f_max_finite(sign_i, P_EXP_W, P_MAN_W));
                    flags_o.overflow = 1'b1;
                    flags_o.inexact  = 1'b1;
                end else if (unf_s) begin
                    data_o            = {sign_i, {(P_W-1){1'b0}}};
                    flags_o.underflow = 1'b1;
                    flags_o.inexact   = 1'b1;
                end else begin
                    data_o = {sign_i, exp_f_s[P_EXP_W-1:0], frac_rnd_s[P_MAN_W-1:0]};
                end
            end
            default: begin
                data_o  = {P_W{1'b0}};
                flags_o = flags_t'(4'b0000);
            end
        endcase
    end

endmodule

// File: rtl/mul_float_pipe.sv
// Three-stage pipelined floating-point multiplier with global-stall back-pressure.
module mul_float_pipe
    import float_mul_pkg::*;
#(
    parameter  int P_EXP_W = 8,
    parameter  int P_MAN_W = 23,
    localparam int P_W     = 1 + P_EXP_W + P_MAN_W
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iRESET_SYNC,
    input  logic           iDATA_REQ,
    output logic           oDATA_BUSY,
    input  logic [P_W-1:0] iDATA_A,
    input  logic [P_W-1:0] iDATA_B,
    input  logic           iDATA_RM,
    output logic           oDATA_VALID,
    input  logic           iDATA_BUSY,
    output logic [P_W-1:0] oDATA,
    output logic [3:0]     oDATA_FLAGS
);

    localparam int EXP_SW = P_EXP_W + 2;
    localparam int PROD_W = 2 * P_MAN_W + 2;
    localparam logic [EXP_SW-1:0] BIAS = EXP_SW'((1 << (P_EXP_W - 1)) - 1);

    function automatic cls_e classify(input logic [P_EXP_W-1:0] e, input logic [P_MAN_W-1:0] f);
        cls_e c;
        if (e == {P_EXP_W{1'b0}}) begin
            c = CLS_ZERO;
        end else if (e == {P_EXP_W{1'b1}}) begin
            c = (f == {P_MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    logic adv_s;
    cls_e cls_a_s, cls_b_s;

    logic                s1_vld_q, s2_vld_q, out_vld_q;
    logic                s1_sign_d, s1_sign_q, s2_sign_q;
    rm_e                 s1_rm_q, s2_rm_q;
    cls_e                s1_cls_d, s1_cls_q, s2_cls_q;
    logic [EXP_SW-1:0]   s1_exp_d, s1_exp_q, s2_exp_q;
    logic [P_MAN_W:0]    s1_man_a_q, s1_man_b_q;
    logic [PROD_W-1:0]   s2_prod_d, s2_prod_q;
    logic [P_W-1:0]      rnd_data_s, out_data_q;
    flags_t              rnd_flags_s, out_flags_q;

    assign adv_s       = !(out_vld_q && iDATA_BUSY);
    assign oDATA_BUSY  = !adv_s;
    assign oDATA_VALID = out_vld_q;
    assign oDATA       = out_data_q;
    assign oDATA_FLAGS = out_flags_q;

    // Unpack: classify operands and resolve the special-value outcome by priority.
    always_comb begin
        cls_a_s   = classify(iDATA_A[P_W-2 -: P_EXP_W], iDATA_A[P_MAN_W-1:0]);
        cls_b_s   = classify(iDATA_B[P_W-2 -: P_EXP_W], iDATA_B[P_MAN_W-1:0]);
        s1_sign_d = iDATA_A[P_W-1] ^ iDATA_B[P_W-1];
        s1_exp_d  = EXP_SW'(iDATA_A[P_W-2 -: P_EXP_W]) + EXP_SW'(iDATA_B[P_W-2 -: P_EXP_W]) - BIAS;
        if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN) ||
            ((cls_a_s == CLS_INF) && (cls_b_s == CLS_ZERO)) ||
            ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_INF))) begin
            s1_cls_d = CLS_NAN;
        end else if ((cls_a_s == CLS_INF) || (cls_b_s == CLS_INF)) begin
            s1_cls_d = CLS_INF;
        end else if ((cls_a_s == CLS_ZERO) || (cls_b_s == CLS_ZERO)) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORM;
        end
        s2_prod_d = PROD_W'(s1_man_a_q) * PROD_W'(s1_man_b_q);
    end

    // Stage valids: all stages move together; a stall freezes the whole pipe.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (iRESET_SYNC) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else if (adv_s) begin
            s1_vld_q  <= iDATA_REQ;
            s2_vld_q  <= s1_vld_q;
            out_vld_q <= s2_vld_q;
        end
    end

    // Datapath registers for the unpack and multiply stages.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            s1_sign_q  <= 1'b0;
            s1_rm_q    <= RM_RNE;
            s1_cls_q   <= CLS_ZERO;
            s1_exp_q   <= {EXP_SW{1'b0}};
            s1_man_a_q <= {(P_MAN_W+1){1'b0}};
            s1_man_b_q <= {(P_MAN_W+1){1'b0}};
            s2_sign_q  <= 1'b0;
            s2_rm_q    <= RM_RNE;
            s2_cls_q   <= CLS_ZERO;
            s2_exp_q   <= {EXP_SW{1'b0}};
            s2_prod_q  <= {PROD_W{1'b0}};
        end else if (adv_s) begin
            s1_sign_q  <= s1_sign_d;
            s1_rm_q    <= rm_e'(iDATA_RM);
            s1_cls_q   <= s1_cls_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_a_q <= {1'b1, iDATA_A[P_MAN_W-1:0]};
            s1_man_b_q <= {1'b1, iDATA_B[P_MAN_W-1:0]};
            s2_sign_q  <= s1_sign_q;
            s2_rm_q    <= s1_rm_q;
            s2_cls_q   <= s1_cls_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= s2_prod_d;
        end
    end

    mul_float_round #(
        .P_EXP_W (P_EXP_W),
        .P_MAN_W (P_MAN_W)
    ) u_round (
        .sign_i  (s2_sign_q),
        .rm_i    (s2_rm_q),
        .cls_i   (s2_cls_q),
        .exp_i   (s2_exp_q),
        .prod_i  (s2_prod_q),
        .data_o  (rnd_data_s),
        .flags_o (rnd_flags_s)
    );

    // Output stage: captures a result only when a real operation leaves S2.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            out_data_q  <= {P_W{1'b0}};
            out_flags_q <= flags_t'(4'b0000);
        end else if (iRESET_SYNC) begin
            out_data_q  <= {P_W{1'b0}};
            out_flags_q <= flags_t'(4'b0000);
        end else if (adv_s && s2_vld_q) begin
            out_data_q  <= rnd_data_s;
            out_flags_q <= rnd_flags_s;
        end
    end

endmodule

// File: tb/tb_mul_float_pipe.sv
// Self-checking bench: vector table through a scoreboard plus stall, reset and half-precision sequences.
module tb_mul_float_pipe;

    logic        clk = 1'b0;
    logic        rst_n, srst, req, rm, ibusy;
    logic [31:0] a, b, dout;
    logic        busy_o, vld;
    logic [3:0]  flg;

    logic        h_req, h_ibusy, h_busy_o, h_vld;
    logic [15:0] h_a, h_b, h_dout;
    logic [3:0]  h_flg;

    always #5 clk = ~clk;

    mul_float_pipe u_dut (
        .iCLOCK (clk), .inRESET (rst_n), .iRESET_SYNC (srst),
        .iDATA_REQ (req), .oDATA_BUSY (busy_o),
        .iDATA_A (a), .iDATA_B (b), .iDATA_RM (rm),
        .oDATA_VALID (vld), .iDATA_BUSY (ibusy),
        .oDATA (dout), .oDATA_FLAGS (flg)
    );

    mul_float_pipe #(.P_EXP_W (5), .P_MAN_W (10)) u_dut_h (
        .iCLOCK (clk), .inRESET (rst_n), .iRESET_SYNC (srst),
        .iDATA_REQ (h_req), .oDATA_BUSY (h_busy_o),
        .iDATA_A (h_a), .iDATA_B (h_b), .iDATA_RM (1'b0),
        .oDATA_VALID (h_vld), .iDATA_BUSY (h_ibusy),
        .oDATA (h_dout), .oDATA_FLAGS (h_flg)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [3:0]  f;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    logic acc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock cycle: record accepted op, score any delivered result, advance to edge+1.
    task automatic cycle();
        exp_t e;
        #1;
        acc = req && !busy_o;
        if (acc) sb.push_back(cur);
        if (vld && !ibusy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data=%h flags=%b with nothing pending", dout, flg);
            end else begin
                e = sb.pop_front();
                if (dout !== e.d || flg !== e.f) begin
                    errors++;
                    $display("FAIL %s: got data=%h flags=%b expected data=%h flags=%b",
                             e.name, dout, flg, e.d, e.f);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        int n;
        req = 1'b1; a = v.a; b = v.b; rm = v.rm;
        cur = '{v.name, v.d, v.f};
        n = 0;
        do begin
            cycle();
            n++;
        end while (!acc && n < 40);
        req = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout_%s: not accepted after %0d cycles", v.name, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] held_d;
        logic [3:0]  held_f;

        vecs.push_back('{"mul_2x3",        32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000});
        vecs.push_back('{"mul_1p5sq",      32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 4'b0000});
        vecs.push_back('{"rne_tie_odd",    32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001});
        vecs.push_back('{"rtz_tie_odd",    32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'b0001});
        vecs.push_back('{"inf_x_zero",     32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"neginf_x_2",     32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000});
        vecs.push_back('{"denorm_flush",   32'h00000001, 32'h40000000, 1'b0, 32'h00000000, 4'b0000});
        vecs.push_back('{"ovf_rne",        32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101});
        vecs.push_back('{"ovf_rtz",        32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101});
        vecs.push_back('{"underflow",      32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011});
        vecs.push_back('{"nan_in",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"neg2_x_3",       32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'b0000});
        vecs.push_back('{"negzero_x_5",    32'h80000000, 32'h40A00000, 1'b0, 32'h80000000, 4'b0000});
        vecs.push_back('{"zero_x_inf",     32'h00000000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"rne_tie_even",   32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'b0001});
        vecs.push_back('{"rne_carry_out",  32'h3FFFF800, 32'h3F800400, 1'b0, 32'h40000000, 4'b0001});
        vecs.push_back('{"rtz_no_carry",   32'h3FFFF800, 32'h3F800400, 1'b1, 32'h3FFFFFFF, 4'b0001});

        rst_n = 1'b0; srst = 1'b0; req = 1'b0; rm = 1'b0; ibusy = 1'b0;
        a = 32'h0; b = 32'h0;
        h_req = 1'b0; h_ibusy = 1'b0; h_a = 16'h0; h_b = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(vld), 32'h0);
        check("reset_data",  dout,     32'h0);
        check("reset_flags", 32'(flg), 32'h0);
        check("reset_busy",  32'(busy_o), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, valid after edge k+2.
        issue(vecs[0]);
        check("latency_k", 32'(vld), 32'h0);
        cycle();
        check("latency_k1", 32'(vld), 32'h0);
        cycle();
        check("latency_k2", 32'(vld), 32'h1);

        for (int i = 1; i < vecs.size(); i++) issue(vecs[i]);
        drain();

        // Back-pressure: output stalled, five back-to-back requests.
        ibusy = 1'b1;
        issue(vecs[0]);
        issue(vecs[2]);
        issue(vecs[11]);
        req = 1'b1; a = vecs[3].a; b = vecs[3].b; rm = vecs[3].rm;
        cur = '{vecs[3].name, vecs[3].d, vecs[3].f};
        #1;
        check("bp_busy_asserted", 32'(busy_o), 32'h1);
        check("bp_valid_held",    32'(vld),    32'h1);
        held_d = dout;
        held_f = flg;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_no_accept", 32'(acc), 32'h0);
            check("bp_data_stable", dout, held_d);
            check("bp_flags_stable", 32'(flg), 32'(held_f));
        end
        ibusy = 1'b0;
        issue(vecs[3]);
        issue(vecs[4]);
        drain();

        // Synchronous reset with three operations in flight.
        ibusy = 1'b1;
        issue(vecs[5]);
        issue(vecs[6]);
        issue(vecs[7]);
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        check("srst_valid", 32'(vld), 32'h0);
        check("srst_data",  dout,     32'h0);
        check("srst_flags", 32'(flg), 32'h0);
        sb.delete();
        ibusy = 1'b0;
        repeat (6) cycle();
        check("srst_no_stale", 32'(vld), 32'h0);
        issue(vecs[1]);
        drain();

        // Asynchronous reset mid-cycle with three operations in flight.
        issue(vecs[8]);
        issue(vecs[9]);
        issue(vecs[10]);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(vld), 32'h0);
        check("arst_data",  dout,     32'h0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cycle();
        check("arst_no_stale", 32'(vld), 32'h0);
        issue(vecs[12]);
        drain();

        // Half-precision instance: 2.0 x 3.0 = 6.0.
        h_req = 1'b1; h_a = 16'h4000; h_b = 16'h4200;
        #1;
        check("half_accept", 32'(h_busy_o), 32'h0);
        @(posedge clk);
        #1;
        h_req = 1'b0;
        n = 0;
        while (!h_vld && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("half_latency", 32'(n), 32'd2);
        check("half_data",  32'(h_dout), 32'h00004600);
        check("half_flags", 32'(h_flg),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
